// File: rtl/pll_lock_sequencer.sv
// PLL power-up/lock sequencer: pulses pll_rst, waits for a qualified lock,
// then releases core_rst. Lock timeouts are retried before the sequencer faults.
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES  = 32,
    parameter int unsigned LOCK_TIMEOUT  = 100000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        ASSERT_RST = 3'd0,
        WAIT_LOCK  = 3'd1,
        STABLE     = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } state_t;

    localparam logic [19:0] RST_LAST  = 20'(RESET_CYCLES - 1);
    localparam logic [19:0] TO_LAST   = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] STB_LAST  = 20'(STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [19:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  loss_q, loss_d;
    logic        sync1_q, lock_s_q;
    logic        pll_rst_q, pll_rst_d;
    logic        core_rst_q, core_rst_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic        enter;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 20'd1;
        retry_d = retry_q;
        loss_d  = loss_q;
        enter   = 1'b0;

        if (restart) begin
            state_d = ASSERT_RST;
            retry_d = '0;
            enter   = 1'b1;
        end else begin
            case (state_q)
                ASSERT_RST: begin
                    if (timer_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        enter   = 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock seen in the timeout cycle takes precedence over the retry.
                    if (lock_s_q) begin
                        state_d = STABLE;
                        enter   = 1'b1;
                    end else if (timer_q == TO_LAST) begin
                        enter = 1'b1;
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 4'd1;
                            state_d = ASSERT_RST;
                        end else begin
                            state_d = FAULT;
                        end
                    end
                end
                STABLE: begin
                    if (!lock_s_q) begin
                        state_d = WAIT_LOCK;
                        enter   = 1'b1;
                    end else if (timer_q == STB_LAST) begin
                        state_d = RUN;
                        enter   = 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s_q) begin
                        state_d = ASSERT_RST;
                        retry_d = '0;
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                        enter   = 1'b1;
                    end
                end
                FAULT: ;
                default: begin
                    state_d = ASSERT_RST;
                    enter   = 1'b1;
                end
            endcase
        end

        if (enter) timer_d = '0;

        // Outputs are decoded from the next state so they register with it.
        pll_rst_d  = (state_d == ASSERT_RST) || (state_d == FAULT);
        core_rst_d = (state_d != RUN);
        ready_d    = (state_d == RUN);
        fault_d    = (state_d == FAULT);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            lock_s_q   <= 1'b0;
            state_q    <= ASSERT_RST;
            timer_q    <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            pll_rst_q  <= 1'b1;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            lock_s_q   <= sync1_q;
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            pll_rst_q  <= pll_rst_d;
            core_rst_q <= core_rst_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign core_rst        = core_rst_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign state           = state_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters;
// expected values are hand-derived cycle counts.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst, pll_locked, restart;
    logic       pll_rst, core_rst, ready, fault;
    logic [2:0] state;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .restart        (restart),
        .pll_rst        (pll_rst),
        .core_rst       (core_rst),
        .ready          (ready),
        .fault          (fault),
        .state          (state),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 refclk = ~refclk;

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int unsigned lim, input string tag);
        int unsigned n = 0;
        while (state !== tgt && n < lim) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(tgt));
    endtask

    initial begin
        rst = 1'b1; pll_locked = 1'b0; restart = 1'b0;
        tick(3);
        check("rst_state",    32'(state), 0);
        check("rst_pll_rst",  32'(pll_rst), 1);
        check("rst_core_rst", 32'(core_rst), 1);
        check("rst_ready",    32'(ready), 0);
        check("rst_fault",    32'(fault), 0);
        check("rst_retry",    32'(retry_count), 0);
        check("rst_loss",     32'(lock_loss_count), 0);

        // Clean lock: pll_rst stays high for exactly 4 cycles after release.
        rst = 1'b0;
        tick(3);
        check("pllrst_hold3", 32'(pll_rst), 1);
        tick();
        check("pllrst_fall",  32'(pll_rst), 0);
        check("wait_lock",    32'(state), 1);
        tick(3);
        pll_locked = 1'b1;
        tick(10);
        check("stable_pre_run", 32'(state), 2);
        check("ready_pre_run",  32'(ready), 0);
        tick();
        check("run_state",    32'(state), 3);
        check("run_ready",    32'(ready), 1);
        check("run_core_rst", 32'(core_rst), 0);

        // Lock loss in RUN: two synchronizer edges, then the transition edge.
        pll_locked = 1'b0;
        tick(2);
        check("loss_still_run", 32'(state), 3);
        check("loss_core_low",  32'(core_rst), 0);
        tick();
        check("loss_state",    32'(state), 0);
        check("loss_core_rst", 32'(core_rst), 1);
        check("loss_count1",   32'(lock_loss_count), 1);
        check("loss_retry",    32'(retry_count), 0);

        // Glitch in STABLE: drop lock for one cycle at STABLE timer 4.
        pll_locked = 1'b1;
        wait_state(3'd2, 20, "reach_stable");
        tick(4);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        check("glitch_still_stable", 32'(state), 2);
        tick();
        check("glitch_wait_lock", 32'(state), 1);
        check("glitch_retry",     32'(retry_count), 0);
        tick();
        check("glitch_relock", 32'(state), 2);
        tick(7);
        check("glitch_pre_run", 32'(state), 2);
        tick();
        check("glitch_run", 32'(state), 3);

        // Never lock: three 4+20 attempts, then FAULT.
        pll_locked = 1'b0;
        tick(3);
        check("nl_assert", 32'(state), 0);
        check("nl_loss2",  32'(lock_loss_count), 2);
        tick(4);
        check("nl_wait1", 32'(state), 1);
        tick(19);
        check("nl_wait1_end",  32'(state), 1);
        check("nl_retry0",     32'(retry_count), 0);
        tick();
        check("nl_retry1_st",  32'(state), 0);
        check("nl_retry1",     32'(retry_count), 1);
        check("nl_retry1_pll", 32'(pll_rst), 1);
        tick(24);
        check("nl_retry2_st", 32'(state), 0);
        check("nl_retry2",    32'(retry_count), 2);
        tick(23);
        check("nl_wait3_end", 32'(state), 1);
        tick();
        check("fault_state",   32'(state), 4);
        check("fault_flag",    32'(fault), 1);
        check("fault_pll_rst", 32'(pll_rst), 1);
        check("fault_core",    32'(core_rst), 1);
        check("fault_ready",   32'(ready), 0);
        tick(5);
        check("fault_held", 32'(state), 4);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("restart_state", 32'(state), 0);
        check("restart_fault", 32'(fault), 0);
        check("restart_retry", 32'(retry_count), 0);
        check("restart_loss",  32'(lock_loss_count), 2);

        // Collision: one timeout first, then lock_s rises in timer cycle 19.
        tick(24);
        check("coll_retry1", 32'(retry_count), 1);
        tick(4);
        check("coll_wait", 32'(state), 1);
        tick(17);
        pll_locked = 1'b1;
        tick(2);
        check("coll_pre", 32'(state), 1);
        tick();
        check("coll_stable", 32'(state), 2);
        check("coll_retry",  32'(retry_count), 1);
        tick(8);
        check("coll_run", 32'(state), 3);

        // 254 more losses bring the total to 256; counter must stop at 255.
        for (int unsigned k = 0; k < 254; k++) begin
            pll_locked = 1'b0;
            wait_state(3'd0, 10, "sat_loss");
            pll_locked = 1'b1;
            wait_state(3'd3, 40, "sat_run");
        end
        check("sat_count", 32'(lock_loss_count), 255);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state", 32'(state), 0);
        check("mid_rst_loss",  32'(lock_loss_count), 0);
        check("mid_rst_core",  32'(core_rst), 1);
        check("mid_rst_ready", 32'(ready), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 Parameter RESET_CYCLES, default 32: cycles `pll_rst` is held high per reset attempt, range 1..2^20-1.
REQ-002 Parameter LOCK_TIMEOUT, default 100000: cycles allowed in WAIT_LOCK before an attempt times out, range 1..2^20-1.
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release, range 1..2^20-1.
REQ-004 Parameter MAX_RETRIES, default 3: timeouts tolerated before FAULT, range 0..15.
REQ-005 refclk  in  1  sole clock; PLL reference clock domain.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pll_locked  in  1  asynchronous lock indication from the PLL.
REQ-008 restart  in  1  single-cycle request to re-run the full sequence.
REQ-009 pll_rst  out  1  reset to the PLL, active-high.
REQ-010 core_rst  out  1  reset to logic clocked by PLL outputs, active-high.
REQ-011 ready  out  1  high only in RUN.
REQ-012 fault  out  1  high only in FAULT.
REQ-013 state  out  3  current state encoding.
REQ-014 retry_count  out  4  timeouts in the current sequence.
REQ-015 lock_loss_count  out  8  saturating count of lock losses seen in RUN.

Function
REQ-016 `pll_locked` SHALL pass through a 2-flop synchronizer (lock_s) before any use; there is no other combinational path from it.
REQ-017 States and encodings SHALL be: ASSERT_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4; all outputs SHALL be registered.
REQ-018 A single 20-bit timer SHALL clear to 0 on every state entry and increment by 1 each cycle within a state.
REQ-019 ASSERT_RST: `pll_rst`=1 and `core_rst`=1; the FSM SHALL exit to WAIT_LOCK after exactly RESET_CYCLES cycles in the state.
REQ-020 WAIT_LOCK: `pll_rst`=0 and `core_rst`=1; when lock_s=1 the FSM SHALL go to STABLE on the next edge.
REQ-021 WAIT_LOCK timeout: when the timer reaches LOCK_TIMEOUT-1 with lock_s=0 and retry_count<MAX_RETRIES, the FSM SHALL increment retry_count and go to ASSERT_RST.
REQ-022 If the timeout occurs with retry_count=MAX_RETRIES, the FSM SHALL go to FAULT.
REQ-023 If lock_s=1 in the timeout cycle, lock wins: the next state is STABLE with no retry increment.
REQ-024 STABLE: `pll_rst`=0 and `core_rst`=1; after STABLE_CYCLES consecutive cycles with lock_s=1 the FSM SHALL enter RUN.
REQ-025 If lock_s drops in STABLE, the FSM SHALL return to WAIT_LOCK with a fresh timeout and no retry increment.
REQ-026 RUN: `pll_rst`=0, `core_rst`=0, `ready`=1; `core_rst` SHALL fall on the same edge that enters RUN.
REQ-027 If lock_s=0 in RUN, the FSM SHALL go to ASSERT_RST, assert `core_rst` on that edge, increment `lock_loss_count` (saturating at 255) and clear `retry_count`.
REQ-028 FAULT: `pll_rst`=1, `core_rst`=1, `fault`=1; FAULT is held until `restart` or `rst`.
REQ-029 `restart`=1 in any state SHALL force ASSERT_RST on the next edge and clear `retry_count`; `lock_loss_count` is kept.
REQ-030 Priority SHALL be: `rst` > `restart` > lock/timeout transitions.

Reset
REQ-031 When `rst`=1 the following values SHALL apply on the next edge: state=ASSERT_RST, timer=0, pll_rst=1, core_rst=1, ready=0, fault=0, retry_count=0, lock_loss_count=0, synchronizer flops=0.
REQ-032 `rst` asserted mid-sequence, including in RUN, SHALL abort immediately with no count updates beyond those in REQ-031.

Verification (RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-033 Clean lock: release `rst`, raise pll_locked 3 cycles after `pll_rst` falls -> `pll_rst` high exactly 4 cycles; `ready`=1 and `core_rst`=0 exactly 2+1+8 cycles after pll_locked rises.
REQ-034 Never lock: pll_locked=0 -> 3 attempts of 4+20 cycles each, retry_count 0→1→2, then `fault`=1, state=4, `pll_rst`=1 held.
REQ-035 Lock glitch in STABLE: drop pll_locked for 1 cycle at STABLE cycle 5 -> return to WAIT_LOCK, retry_count unchanged, RUN reached 8 cycles after relock.
REQ-036 Lock loss in RUN: deassert pll_locked -> `core_rst`=1 and state=0 exactly 3 edges later, lock_loss_count=1, retry_count=0; 256 losses saturate at 255.
REQ-037 Timeout/lock collision: lock_s rises in WAIT_LOCK timer cycle 19 -> STABLE, retry_count unchanged; `restart` in FAULT -> ASSERT_RST, fault=0, retry_count=0.
